discharge_run_param_ctrl: RTL
=============================

Name: discharge_run_param_ctrl

Overview:
- Parametrised run-control and parameter-delivery front end for the EDM pulse generator, placed between the command sources (SPI, keys, host extras) and the mos_control pulse engine.
- Generalises start/stop handling to N_SRC sources and parameter delivery to N_PARAM async-captured, range-clamped values.
- Parameters are double-buffered and committed atomically only at discharge-cycle boundaries.
- Adds a graceful-stop drain state with timeout, and a fault latch.

Parameters:
- N_SRC, 2, number of start/stop command sources; machine runs only when every source enables it.
- SRC_EN_RST, 2'b10, per-source enable value at reset, bit i = source i.
- N_PARAM, 4, number of parameters (index 0 Ton, 1 Toff, 2 Ip, 3 waveform).
- DW, 16, parameter width in bits, unsigned.
- SYNC_STAGES, 2, flops in each change_ack synchroniser, minimum 2.
- PARAM_RST, {16'd0,16'd8,16'd20,16'd10}, packed reset value of staged and active registers; param p occupies bits [p*DW +: DW].
- PARAM_MIN, {16'd0,16'd1,16'd1,16'd1}, packed lower clamp bounds.
- PARAM_MAX, {16'hFFFF,16'd78,16'd1000,16'd500}, packed upper clamp bounds.
- STOP_TIMEOUT, 20000, clk cycles allowed in DRAIN before a forced stop (200us).

Ports:
- clk  in  1  100MHz system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_ack  in  N_SRC  one-cycle start pulse, one bit per source.
- stop_ack  in  N_SRC  one-cycle stop pulse, one bit per source.
- change_ack  in  N_PARAM  asynchronous per-parameter update strobe, high for at least SYNC_STAGES+1 clk.
- param_async  in  N_PARAM*DW  asynchronous parameter data, stable while the matching change_ack is high.
- cycle_boundary  in  1  one-cycle pulse from the pulse engine at the end of each Toff.
- fault_in  in  1  level fault request (e.g. overcurrent).
- clr_status  in  1  one-cycle pulse; clears sticky flags and releases FAULT.
- is_machine  out  1  run enable to the pulse engine.
- finish_req  out  1  high in DRAIN; engine must finish its current cycle.
- run_state  out  2  FSM state code.
- param_active  out  N_PARAM*DW  committed parameters feeding the engine.
- param_pending  out  N_PARAM  staged value awaiting commit.
- param_clamped  out  N_PARAM  sticky, set when a captured value was clamped.
- stop_timeout_err  out  1  sticky, set when DRAIN ended by timeout.

Behaviour:
- Reset values:
  - src_en = SRC_EN_RST; FSM in IDLE.
  - is_machine = 0, finish_req = 0.
  - staged and param_active = PARAM_RST.
  - param_pending = 0, param_clamped = 0, stop_timeout_err = 0.
  - Synchronisers and the drain counter cleared.
- Source enables:
  - start_ack[i] sets src_en[i]; stop_ack[i] clears it.
  - If both arrive in the same cycle, stop wins.
  - run_req = &src_en.
- FSM, run_state encoding IDLE=00, RUN=01, DRAIN=10, FAULT=11:
  - IDLE -> RUN on run_req=1 and fault_in=0.
  - RUN -> DRAIN when run_req=0.
  - DRAIN -> IDLE on cycle_boundary, or when the drain counter reaches STOP_TIMEOUT-1; the timeout path also sets stop_timeout_err.
  - A reasserted run_req during DRAIN is ignored until IDLE is reached, then re-evaluated.
  - fault_in=1 forces FAULT from any state and has highest priority.
  - FAULT -> IDLE on clr_status with fault_in=0.
  - is_machine = (RUN or DRAIN), registered, so it rises one cycle after the state changes.
  - The drain counter clears on entry to DRAIN.
- Capture path, per parameter:
  - change_ack passes through SYNC_STAGES flops, then a rising-edge detector.
  - On the detected edge, staged[p] = clamp(param_async[p], PARAM_MIN[p], PARAM_MAX[p]) using unsigned compare.
  - The same edge sets param_pending[p], and sets param_clamped[p] if the value was out of range.
  - A second edge before commit overwrites staged[p]; last value wins.
- Commit:
  - In IDLE or FAULT, pending params commit the cycle after capture. Total latency from change_ack rise to param_active is SYNC_STAGES+2 clk.
  - In RUN or DRAIN, all pending params commit together on cycle_boundary, so Ton, Toff and Ip never mix generations within one cycle.
  - Committed params clear their pending bit.
- Capture and commit in the same cycle for one param: the old staged value commits, the new value is stored in staged, and pending stays 1.
- clr_status clears param_clamped and stop_timeout_err. If a clamp event occurs in the same cycle, the set wins.

Decomposition:
- Shared package discharge_pkg holds:
  - the state typedef/localparams IDLE/RUN/DRAIN/FAULT;
  - the param index constants IDX_TON=0, IDX_TOFF=1, IDX_IP=2, IDX_WAVE=3.
- Sub-module param_sync_capture handles one parameter: synchroniser, edge detect, clamp, staged register and pending/clamped flags.
- The top level instantiates N_PARAM copies of param_sync_capture in a generate loop and contains the FSM and commit logic.

Test Plan:
- Reset with defaults -> is_machine=0, run_state=00, param_active={0,8,20,10}. Pulse start_ack[0] -> run_req=1, RUN within 1 clk, is_machine=1 the next clk.
- In RUN: stop_ack[1] then no cycle_boundary for 20000 clk -> DRAIN for 20000 clk, then IDLE, is_machine=0, stop_timeout_err=1. Repeat with cycle_boundary at clk 50 -> IDLE at clk 51, stop_timeout_err stays 0 after clr_status.
- In RUN: change_ack[IDX_TON] with data 16'd30 -> param_pending[0]=1 and param_active Ton unchanged until cycle_boundary, then 30 and pending=0. In IDLE: same stimulus -> Ton=30 at SYNC_STAGES+2 clk.
- Ip data 16'd120 -> staged Ip=78, param_clamped[2]=1. Toff data 0 -> staged Toff=1, param_clamped[1]=1.
- start_ack[0] and stop_ack[0] in the same clk -> src_en[0]=0, FSM stays IDLE.
- fault_in during RUN -> FAULT next clk, is_machine=0. clr_status while fault_in=1 -> remains FAULT. Drop fault_in, then clr_status -> IDLE.

Source files
------------

// File: rtl/discharge_pkg.sv
// discharge_pkg: shared run-state encoding and parameter index constants
package discharge_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10,
    FAULT = 2'b11
  } run_state_t;
  localparam int IDX_TON  = 0;
  localparam int IDX_TOFF = 1;
  localparam int IDX_IP   = 2;
  localparam int IDX_WAVE = 3;
endpackage

// File: rtl/param_sync_capture.sv
// param_sync_capture: synchronise one change strobe, clamp and stage its value
module param_sync_capture #(
  parameter int DW = 16,
  parameter int SYNC_STAGES = 2,
  parameter logic [DW-1:0] RST_VAL = '0,
  parameter logic [DW-1:0] MIN_VAL = '0,
  parameter logic [DW-1:0] MAX_VAL = '1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          change_ack,
  input  logic [DW-1:0] param_async,
  input  logic          commit,
  input  logic          clr_status,
  output logic [DW-1:0] staged,
  output logic          pending,
  output logic          clamped
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic edge_q, rise, lo, hi;
  logic [DW-1:0] clamp_val;
  // Borrow bit of an extended subtraction gives the unsigned compare
  assign lo = 1'(({1'b0, param_async} - {1'b0, MIN_VAL}) >> DW);
  assign hi = 1'(({1'b0, MAX_VAL} - {1'b0, param_async}) >> DW);
  assign clamp_val = lo ? MIN_VAL : hi ? MAX_VAL : param_async;
  assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;
  // Synchroniser, edge detect, staging and sticky flags; a fresh capture beats a commit clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
      staged  <= RST_VAL;
      pending <= 1'b0;
      clamped <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], change_ack};
      edge_q  <= sync_q[SYNC_STAGES-1];
      staged  <= rise ? clamp_val : staged;
      pending <= rise | (pending & ~commit);
      clamped <= (rise & (lo | hi)) | (clamped & ~clr_status);
    end
  end
endmodule

// File: rtl/discharge_run_param_ctrl.sv
// discharge_run_param_ctrl: run/stop FSM with drain and fault, plus atomic parameter commit
module discharge_run_param_ctrl
  import discharge_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter logic [N_SRC-1:0] SRC_EN_RST = 2'b10,
  parameter int N_PARAM = 4,
  parameter int DW = 16,
  parameter int SYNC_STAGES = 2,
  parameter logic [N_PARAM*DW-1:0] PARAM_RST = {16'd0, 16'd8, 16'd20, 16'd10},
  parameter logic [N_PARAM*DW-1:0] PARAM_MIN = {16'd0, 16'd1, 16'd1, 16'd1},
  parameter logic [N_PARAM*DW-1:0] PARAM_MAX = {16'hFFFF, 16'd78, 16'd1000, 16'd500},
  parameter int STOP_TIMEOUT = 20000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_SRC-1:0]      start_ack,
  input  logic [N_SRC-1:0]      stop_ack,
  input  logic [N_PARAM-1:0]    change_ack,
  input  logic [N_PARAM*DW-1:0] param_async,
  input  logic                  cycle_boundary,
  input  logic                  fault_in,
  input  logic                  clr_status,
  output logic                  is_machine,
  output logic                  finish_req,
  output logic [1:0]            run_state,
  output logic [N_PARAM*DW-1:0] param_active,
  output logic [N_PARAM-1:0]    param_pending,
  output logic [N_PARAM-1:0]    param_clamped,
  output logic                  stop_timeout_err
);
  localparam int CW = STOP_TIMEOUT > 1 ? $clog2(STOP_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STOP_TIMEOUT - 1);
  logic [N_SRC-1:0] src_en;
  logic run_req, timeout_exit, commit_en;
  run_state_t state, state_nxt;
  logic [CW-1:0] drain_cnt;
  logic [N_PARAM*DW-1:0] staged;
  assign run_req = &src_en;
  assign run_state = state;
  assign timeout_exit = !fault_in && state == DRAIN && !cycle_boundary && drain_cnt == CNT_MAX;
  assign commit_en = state == IDLE || state == FAULT || cycle_boundary;
  // Per-source enables; a stop in the same cycle as a start wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) src_en <= SRC_EN_RST;
    else src_en <= (src_en | start_ack) & ~stop_ack;
  end
  // Next state; fault has absolute priority, drain ignores run_req until IDLE
  always_comb begin
    state_nxt = state;
    if (fault_in) state_nxt = FAULT;
    else if (state == IDLE && run_req) state_nxt = RUN;
    else if (state == RUN && !run_req) state_nxt = DRAIN;
    else if (state == DRAIN && (cycle_boundary || timeout_exit)) state_nxt = IDLE;
    else if (state == FAULT && clr_status) state_nxt = IDLE;
  end
  // State, registered outputs, drain counter and timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      is_machine       <= 1'b0;
      finish_req       <= 1'b0;
      drain_cnt        <= '0;
      stop_timeout_err <= 1'b0;
    end else begin
      state            <= state_nxt;
      is_machine       <= state == RUN || state == DRAIN;
      finish_req       <= state_nxt == DRAIN;
      drain_cnt        <= state == DRAIN ? drain_cnt + 1'b1 : '0;
      stop_timeout_err <= timeout_exit | (stop_timeout_err & ~clr_status);
    end
  end
  for (genvar g = 0; g < N_PARAM; g++) begin : g_param
    param_sync_capture #(
      .DW(DW),
      .SYNC_STAGES(SYNC_STAGES),
      .RST_VAL(PARAM_RST[g*DW +: DW]),
      .MIN_VAL(PARAM_MIN[g*DW +: DW]),
      .MAX_VAL(PARAM_MAX[g*DW +: DW])
    ) u_cap (
      .clk(clk),
      .rst_n(rst_n),
      .change_ack(change_ack[g]),
      .param_async(param_async[g*DW +: DW]),
      .commit(commit_en),
      .clr_status(clr_status),
      .staged(staged[g*DW +: DW]),
      .pending(param_pending[g]),
      .clamped(param_clamped[g])
    );
  end
  // Commit all pending params together so one discharge cycle never mixes generations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) param_active <= PARAM_RST;
    else for (int i = 0; i < N_PARAM; i++)
      if (commit_en && param_pending[i]) param_active[i*DW +: DW] <= staged[i*DW +: DW];
  end
endmodule
